// File: rtl/fp16_accum.sv
// fp16_accum: sums a stream of FP16 products into an FP16 accumulator.
// It emits the sum after every N_TERMS absorbed terms.
// The arithmetic uses IEEE half format with truncation. Overflow saturates
// to infinity and sets a sticky flag. Subnormals are flushed to zero.
// Each term takes 4 cycles (IDLE accept, ALIGN, ADD, NORM). The producer is
// throttled with a ready/valid handshake.
//
// Ports:
//   CLK, RST      clock (rising edge), synchronous active-high reset
//   in_valid      product word valid
//   in_ready      block accepts a product this cycle (high only in IDLE)
//   in_data       FP16 product
//   in_ovf        product overflowed upstream: force infinity
//   in_sub        product underflowed upstream: treat as zero
//   out_valid     one-cycle pulse; out_data/out_overflow hold the result
//   out_data      FP16 accumulated sum (held until the next result)
//   out_overflow  sticky overflow of that sum
//   term_cnt      terms absorbed into the current sum
module fp16_accum #(
  parameter int N_TERMS = 4,
  parameter int CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_data,
  input  logic             in_ovf,
  input  logic             in_sub,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_overflow,
  output logic [CNT_W-1:0] term_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [15:0]      acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_ovf_q, out_ovf_d;

  logic [15:0]       b_p0_q;
  logic              bovf_p0_q, bsub_p0_q;
  logic              s_p1_q, sub_p1_q;
  logic signed [6:0] e_p1_q;
  logic [10:0]       ma_p1_q, mb_p1_q;
  logic              s_p2_q;
  logic signed [6:0] e_p2_q;
  logic [11:0]       sum_p2_q;

  // Leading-zero count of an 11-bit mantissa (11 when all zero).
  function automatic logic [3:0] lzc11(input logic [10:0] m);
    logic [3:0] n;
    n = 4'd11;
    for (int i = 0; i < 11; i++)
      if (m[i]) n = 4'(10 - i);
    return n;
  endfunction

  // Normalizes a 12-bit raw sum with truncation and packs it to FP16.
  // Results that underflow are flushed to zero. Results that overflow
  // saturate to infinity. Bit 16 of the result flags the overflow.
  function automatic logic [16:0] norm_pack(input logic s,
                                            input logic signed [6:0] e,
                                            input logic [11:0] m);
    logic [11:0]       mm;
    logic signed [6:0] ee;
    logic [3:0]        lz;
    mm = m;
    ee = e;
    lz = 4'd0;
    if (m == 12'd0) return 17'h0;
    if (m[11]) begin
      mm = m >> 1;
      ee = e + 7'sd1;
    end else begin
      lz = lzc11(m[10:0]);
      mm = m << lz;
      ee = e - $signed({3'b000, lz});
    end
    if (ee <= 7'sd0)  return 17'h0;
    if (ee >= 7'sd31) return {1'b1, s, 15'h7C00};
    return {1'b0, s, ee[4:0], mm[9:0]};
  endfunction

  // ALIGN: unpack, order by magnitude, truncate-shift the smaller operand.
  logic        a_zero, b_zero, swap, big_s, sml_s;
  logic [14:0] a_mag, b_mag;
  logic [10:0] a_m, b_m, big_m, sml_m, sml_sh;
  logic [4:0]  big_e, sml_e, diff;

  always_comb begin
    a_zero = (acc_q[14:10] == 5'd0);
    b_zero = (b_p0_q[14:10] == 5'd0) || bsub_p0_q;
    a_mag  = a_zero ? 15'd0 : acc_q[14:0];
    b_mag  = b_zero ? 15'd0 : b_p0_q[14:0];
    a_m    = a_zero ? 11'd0 : {1'b1, acc_q[9:0]};
    b_m    = b_zero ? 11'd0 : {1'b1, b_p0_q[9:0]};
    swap   = (b_mag > a_mag);
    big_s  = swap ? b_p0_q[15] : acc_q[15];
    sml_s  = swap ? acc_q[15] : b_p0_q[15];
    big_e  = swap ? b_mag[14:10] : a_mag[14:10];
    sml_e  = swap ? a_mag[14:10] : b_mag[14:10];
    big_m  = swap ? b_m : a_m;
    sml_m  = swap ? a_m : b_m;
    diff   = big_e - sml_e;
    sml_sh = (diff >= 5'd11) ? 11'd0 : (sml_m >> diff);
  end

  // ADD: magnitude add or subtract. The larger operand is always in A,
  // so subtraction never goes negative.
  logic [11:0] sum_d;
  always_comb begin
    sum_d = sub_p1_q ? ({1'b0, ma_p1_q} - {1'b0, mb_p1_q})
                     : ({1'b0, ma_p1_q} + {1'b0, mb_p1_q});
  end

  // NORM: pack the result. An overflowed or infinite/NaN product replaces
  // the sum with a signed infinity.
  logic [16:0] np;
  logic        force_inf;
  always_comb begin
    np        = norm_pack(s_p2_q, e_p2_q, sum_p2_q);
    force_inf = bovf_p0_q || (b_p0_q[14:10] == 5'h1F);
  end

  always_ff @(posedge CLK) begin
    // p0: operand capture on transfer
    if (state_q == S_IDLE && in_valid) begin
      b_p0_q    <= in_data;
      bovf_p0_q <= in_ovf;
      bsub_p0_q <= in_sub;
    end
    // p1: aligned operands
    if (state_q == S_ALIGN) begin
      s_p1_q   <= big_s;
      sub_p1_q <= big_s ^ sml_s;
      e_p1_q   <= $signed({2'b00, big_e});
      ma_p1_q  <= big_m;
      mb_p1_q  <= sml_sh;
    end
    // p2: raw sum
    if (state_q == S_ADD) begin
      s_p2_q   <= s_p1_q;
      e_p2_q   <= e_p1_q;
      sum_p2_q <= sum_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
    acc_d       = acc_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM: begin
        cnt_d = cnt_q + 1'b1;
        // Once saturated the sum holds its infinity; terms are only counted.
        if (!sticky_q) begin
          if (force_inf) begin
            acc_d    = {b_p0_q[15], 15'h7C00};
            sticky_d = 1'b1;
          end else begin
            acc_d    = np[15:0];
            sticky_d = np[16];
          end
        end
        if (cnt_d == CNT_W'(N_TERMS)) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
          out_data_d  = acc_d;
          out_ovf_d   = sticky_d;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        acc_d    = 16'h0000;
        cnt_d    = '0;
        sticky_d = 1'b0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sticky_q    <= 1'b0;
      acc_q       <= 16'h0000;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0000;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_overflow = out_ovf_q;
  assign term_cnt     = cnt_q;

endmodule

// File: tb/tb_fp16_accum.sv
module tb_fp16_accum;
  localparam int N  = 4;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic          in_valid, in_ready, in_ovf, in_sub;
  logic          out_valid, out_overflow;
  logic [15:0]   in_data, out_data;
  logic [CW-1:0] term_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [16:0] exp_q[$];
  int          xfer_cyc[$];
  logic [15:0] m_acc;
  logic        m_sticky;
  int          m_cnt;
  logic [16:0] mon_e;

  fp16_accum #(.N_TERMS(N), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_ovf(in_ovf), .in_sub(in_sub),
    .out_valid(out_valid), .out_data(out_data),
    .out_overflow(out_overflow), .term_cnt(term_cnt)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference FP16 add: value = mant * 2^(exp-25). The smaller operand is
  // floor-divided to the larger one's scale, then the result keeps its top
  // 11 significant bits.
  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    int ea, eb, ma, mb, sa, sb, t, r, p, e, m;
    logic [31:0] ebits, mbits;
    ea = int'(a[14:10]); eb = int'(b[14:10]);
    ma = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    mb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    if (ma == 0) ea = 0;
    if (mb == 0) eb = 0;
    sa = int'(a[15]); sb = int'(b[15]);
    if (ma == 0 && mb == 0) return 17'h0;
    if (eb > ea || (eb == ea && mb > ma)) begin
      t = ea; ea = eb; eb = t;
      t = ma; ma = mb; mb = t;
      t = sa; sa = sb; sb = t;
    end
    mb = mb / (2 ** (ea - eb));
    r  = (sa == sb) ? ma + mb : ma - mb;
    if (r == 0) return 17'h0;
    p = 0;
    for (int i = 0; i < 12; i++) if (((r >> i) & 1) == 1) p = i;
    e = ea + p - 10;
    m = (p > 10) ? (r >> (p - 10)) : (r << (10 - p));
    if (e <= 0)  return 17'h0;
    if (e >= 31) return {1'b1, sa[0], 15'h7C00};
    ebits = e; mbits = m;
    return {1'b0, sa[0], ebits[4:0], mbits[9:0]};
  endfunction

  task automatic model_reset();
    m_acc = 16'h0; m_sticky = 1'b0; m_cnt = 0;
  endtask

  task automatic model_accept(input logic [15:0] d, input logic ovf, input logic sub);
    logic [16:0] r;
    if (!m_sticky) begin
      if (ovf || d[14:10] == 5'h1F) begin
        m_acc = {d[15], 15'h7C00}; m_sticky = 1'b1;
      end else begin
        r = ref_add(m_acc, sub ? 16'h0000 : d);
        m_acc = r[15:0]; m_sticky = r[16];
      end
    end
    m_cnt++;
    if (m_cnt == N) begin
      exp_q.push_back({m_sticky, m_acc});
      model_reset();
    end
  endtask

  // Called at posedge+1; returns at posedge+1 just after the transfer edge.
  task automatic send(input logic [15:0] d, input logic ovf, input logic sub);
    int guard;
    in_data = d; in_ovf = ovf; in_sub = sub; in_valid = 1'b1;
    guard = 0;
    @(negedge CLK);
    while (!in_ready && guard < 50) begin
      @(negedge CLK);
      guard++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
    end else begin
      chk("term_cnt_at_xfer", 32'(term_cnt), 32'(m_cnt));
      xfer_cyc.push_back(cyc);
      model_accept(d, ovf, sub);
    end
    @(posedge CLK); #1;
  endtask

  function automatic logic [15:0] rnd_fp();
    logic [4:0] e;
    logic [9:0] f;
    logic       s;
    s = 1'($urandom_range(0, 1));
    f = 10'($urandom);
    case ($urandom_range(0, 9))
      0:       e = 5'd0;
      1:       e = 5'($urandom_range(25, 30));
      default: e = 5'($urandom_range(10, 20));
    endcase
    return {s, e, f};
  endfunction

  // Scoreboard monitor: every result pulse is matched against the model.
  always @(negedge CLK) begin
    if (!RST && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(mon_e[15:0]));
        chk("out_overflow", 32'(out_overflow), 32'(mon_e[16]));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    RST = 1'b1; in_valid = 1'b0; in_data = 16'h0; in_ovf = 1'b0; in_sub = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_overflow", 32'(out_overflow), 32'd0);
    chk("rst_term_cnt", 32'(term_cnt), 32'd0);
    @(posedge CLK); #1;

    // Held valid: one transfer every 4 cycles.
    xfer_cyc.delete();
    repeat (4) send(16'h3C00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      chk("xfer_spacing", 32'(xfer_cyc[i+1] - xfer_cyc[i]), 32'd4);

    send(16'h4000, 1'b0, 1'b0); send(16'hC000, 1'b0, 1'b0);
    send(16'h3E00, 1'b0, 1'b0); send(16'h0000, 1'b0, 1'b0);

    send(16'h7BFF, 1'b0, 1'b0); send(16'h7BFF, 1'b0, 1'b0);
    send(16'h3C00, 1'b0, 1'b0); send(16'h3C00, 1'b0, 1'b0);
    repeat (4) send(16'h3C00, 1'b0, 1'b0);

    send(16'h3C00, 1'b0, 1'b0); send(16'h0C00, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b0); send(16'h0000, 1'b0, 1'b0);
    send(16'h3C00, 1'b0, 1'b0); send(16'h0001, 1'b0, 1'b1);
    send(16'h0000, 1'b0, 1'b0); send(16'h0000, 1'b0, 1'b0);

    send(16'h3C00, 1'b0, 1'b0); send(16'hC123, 1'b1, 1'b0);
    send(16'h3C00, 1'b0, 1'b0); send(16'h3C00, 1'b0, 1'b0);

    // Reset during ADD of term 2 aborts the partial sum.
    send(16'h3C00, 1'b0, 1'b0); send(16'h4000, 1'b0, 1'b0);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    model_reset();
    @(negedge CLK);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_term_cnt", 32'(term_cnt), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    @(posedge CLK); #1;
    send(16'h4000, 1'b0, 1'b0); send(16'h3C00, 1'b0, 1'b0);
    send(16'h3800, 1'b0, 1'b0); send(16'h3400, 1'b0, 1'b0);

    // Randomized products with random valid gaps.
    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge CLK);
        #1;
      end
      send(rnd_fp(), ($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0));
    end
    in_valid = 1'b0;

    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge CLK);
      guard++;
    end
    chk("results_drained", 32'(exp_q.size()), 32'd0);
    repeat (10) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
